// File: rtl/exc_ctrl_if.sv
// Purpose: MEM-stage exception bundle: instruction status, exception flags,
//          CP0 register views in; CP0 commit data and pipeline flush/redirect out.
// Modports: master drives the MEM/CP0 side (pipeline), slave is the controller.
interface exc_ctrl_if;
    // MEM-stage instruction and exception flags
    logic        m_valid;
    logic        m_stall;
    logic [31:0] m_pc;
    logic        m_is_bd;
    logic [31:0] m_addr;
    logic        f_adel;
    logic        d_ri;
    logic        e_ov;
    logic        d_sys;
    logic        d_bp;
    logic        m_adel;
    logic        m_ades;
    logic        m_eret;
    // CP0 register views
    logic [31:0] cp0_status;
    logic [31:0] cp0_cause;
    logic [31:0] cp0_epc;
    // CP0 commit data
    logic        is_valid_exc;
    logic [31:0] epc_wdata;
    logic        cause_bd_wdata;
    logic [4:0]  cause_exccode_wdata;
    logic        badvaddr_wen;
    logic [31:0] badvaddr_wdata;
    logic        eret_commit;
    // pipeline control
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output m_valid, m_stall, m_pc, m_is_bd, m_addr,
               f_adel, d_ri, e_ov, d_sys, d_bp, m_adel, m_ades, m_eret,
               cp0_status, cp0_cause, cp0_epc,
        input  is_valid_exc, epc_wdata, cause_bd_wdata, cause_exccode_wdata,
               badvaddr_wen, badvaddr_wdata, eret_commit,
               flush, redirect_valid, redirect_pc
    );

    modport slave (
        input  m_valid, m_stall, m_pc, m_is_bd, m_addr,
               f_adel, d_ri, e_ov, d_sys, d_bp, m_adel, m_ades, m_eret,
               cp0_status, cp0_cause, cp0_epc,
        output is_valid_exc, epc_wdata, cause_bd_wdata, cause_exccode_wdata,
               badvaddr_wen, badvaddr_wdata, eret_commit,
               flush, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/exc_ctrl.sv
// Purpose: MEM-stage exception/interrupt controller; prioritises exceptions, drives CP0 commit, flush and redirect.
// Latency: commit request is combinational in the detect cycle; redirect one cycle after the commit cycle.
// Backpressure: m_stall holds the commit request (HOLD) until release; ERET waits in IDLE while stalled.
// Ports: clk, resetn (async active-low), bus (exc_ctrl_if.slave) carrying all MEM/CP0 signals.
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic       clk,
    input  logic       resetn,
    exc_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, HOLD, FLUSH} state_t;

    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        first_q, first_d;      // high on the FLUSH entry cycle only
    logic [31:0] target_q, target_d;
    logic        int_pend_q;

    // write data captured at detection, replayed while HOLD
    logic [31:0] epc_q, bv_q;
    logic        bd_q, bvw_q;
    logic [4:0]  code_q;
    logic        lat_en;

    // live exception decode
    logic        exc_hit;
    logic [4:0]  exc_code;
    logic        exc_bvw;
    logic [31:0] exc_bv;
    logic [31:0] epc_live;

    // output staging
    logic        o_ivx, o_bd, o_bvw, o_eret, o_flush, o_rv;
    logic [4:0]  o_code;
    logic [31:0] o_epc, o_bv, o_rpc;

    // only the interrupt fields of Status/Cause matter here
    logic unused_cp0_bits;
    assign unused_cp0_bits = ^{bus.cp0_status[31:16], bus.cp0_status[7:2],
                               bus.cp0_cause[31:16], bus.cp0_cause[7:0]};

    assign epc_live = bus.m_is_bd ? (bus.m_pc - 32'd4) : bus.m_pc;

    // fixed priority: Int, AdEL(fetch), RI, Ov, Sys, Bp, AdEL(data), AdES
    always_comb begin
        exc_hit  = 1'b1;
        exc_code = 5'd0;
        exc_bvw  = 1'b0;
        exc_bv   = 32'd0;
        if (int_pend_q) begin
            exc_code = 5'd0;
        end else if (bus.f_adel) begin
            exc_code = 5'd4;
            exc_bvw  = 1'b1;
            exc_bv   = bus.m_pc;
        end else if (bus.d_ri) begin
            exc_code = 5'd10;
        end else if (bus.e_ov) begin
            exc_code = 5'd12;
        end else if (bus.d_sys) begin
            exc_code = 5'd8;
        end else if (bus.d_bp) begin
            exc_code = 5'd9;
        end else if (bus.m_adel) begin
            exc_code = 5'd4;
            exc_bvw  = 1'b1;
            exc_bv   = bus.m_addr;
        end else if (bus.m_ades) begin
            exc_code = 5'd5;
            exc_bvw  = 1'b1;
            exc_bv   = bus.m_addr;
        end else begin
            exc_hit  = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        first_d  = 1'b0;
        target_d = target_q;
        lat_en   = 1'b0;
        o_ivx    = 1'b0;
        o_epc    = 32'd0;
        o_bd     = 1'b0;
        o_code   = 5'd0;
        o_bvw    = 1'b0;
        o_bv     = 32'd0;
        o_eret   = 1'b0;
        o_flush  = 1'b0;
        o_rv     = 1'b0;
        o_rpc    = 32'd0;

        case (state_q)
            IDLE: begin
                if (bus.m_valid && exc_hit) begin
                    o_ivx  = 1'b1;
                    o_epc  = epc_live;
                    o_bd   = bus.m_is_bd;
                    o_code = exc_code;
                    o_bvw  = exc_bvw;
                    o_bv   = exc_bv;
                    lat_en = 1'b1;
                    if (!bus.m_stall) begin
                        state_d  = FLUSH;
                        cnt_d    = FLUSH_LAST;
                        first_d  = 1'b1;
                        target_d = EXC_VECTOR;
                    end else begin
                        state_d  = HOLD;
                    end
                end else if (bus.m_valid && bus.m_eret && !bus.m_stall) begin
                    o_eret   = 1'b1;
                    state_d  = FLUSH;
                    cnt_d    = FLUSH_LAST;
                    first_d  = 1'b1;
                    target_d = bus.cp0_epc;
                end
            end
            HOLD: begin
                o_ivx  = 1'b1;
                o_epc  = epc_q;
                o_bd   = bd_q;
                o_code = code_q;
                o_bvw  = bvw_q;
                o_bv   = bv_q;
                if (!bus.m_stall) begin
                    state_d  = FLUSH;
                    cnt_d    = FLUSH_LAST;
                    first_d  = 1'b1;
                    target_d = EXC_VECTOR;
                end
            end
            FLUSH: begin
                o_flush = 1'b1;
                o_rv    = first_q;
                o_rpc   = first_q ? target_q : 32'd0;
                if (cnt_q == 3'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // IDLE decode is combinational on live inputs, so silence it in reset
        if (!resetn) begin
            o_ivx   = 1'b0;
            o_epc   = 32'd0;
            o_bd    = 1'b0;
            o_code  = 5'd0;
            o_bvw   = 1'b0;
            o_bv    = 32'd0;
            o_eret  = 1'b0;
            o_flush = 1'b0;
            o_rv    = 1'b0;
            o_rpc   = 32'd0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            first_q    <= 1'b0;
            target_q   <= 32'd0;
            int_pend_q <= 1'b0;
            epc_q      <= 32'd0;
            bd_q       <= 1'b0;
            code_q     <= 5'd0;
            bvw_q      <= 1'b0;
            bv_q       <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            first_q    <= first_d;
            target_q   <= target_d;
            int_pend_q <= (|(bus.cp0_cause[15:8] & bus.cp0_status[15:8]))
                          & bus.cp0_status[0] & ~bus.cp0_status[1];
            if (lat_en) begin
                epc_q  <= epc_live;
                bd_q   <= bus.m_is_bd;
                code_q <= exc_code;
                bvw_q  <= exc_bvw;
                bv_q   <= exc_bv;
            end
        end
    end

    assign bus.is_valid_exc        = o_ivx;
    assign bus.epc_wdata           = o_epc;
    assign bus.cause_bd_wdata      = o_bd;
    assign bus.cause_exccode_wdata = o_code;
    assign bus.badvaddr_wen        = o_bvw;
    assign bus.badvaddr_wdata      = o_bv;
    assign bus.eret_commit         = o_eret;
    assign bus.flush               = o_flush;
    assign bus.redirect_valid      = o_rv;
    assign bus.redirect_pc         = o_rpc;

endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;

    localparam logic [31:0] VEC = 32'hBFC0_0380;
    localparam int          FC  = 1;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    exc_ctrl_if bus();

    exc_ctrl dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: a pending (stalled) commit record, a flush countdown,
    // and a one-shot redirect with its target
    bit          mdl_int_pend;
    bit          mdl_pending;
    int          mdl_flush_left;
    bit          mdl_redirect_due;
    logic [31:0] mdl_target;
    logic [31:0] pend_epc, pend_bv;
    logic        pend_bd, pend_bvw;
    logic [4:0]  pend_code;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // exception table in priority order; index 1 = fetch AdEL, 6/7 = data faults
    task automatic classify(output bit hit, output logic [4:0] code,
                            output bit bvw, output logic [31:0] bv);
        bit         fl[8];
        logic [4:0] codes[8];
        codes = '{5'd0, 5'd4, 5'd10, 5'd12, 5'd8, 5'd9, 5'd4, 5'd5};
        fl    = '{mdl_int_pend, bus.f_adel, bus.d_ri, bus.e_ov,
                  bus.d_sys, bus.d_bp, bus.m_adel, bus.m_ades};
        hit = 0; code = 5'd0; bvw = 0; bv = 32'd0;
        for (int i = 0; i < 8; i++) begin
            if (fl[i] && !hit) begin
                hit  = 1;
                code = codes[i];
                if (i == 1) begin bvw = 1; bv = bus.m_pc; end
                if (i >= 6) begin bvw = 1; bv = bus.m_addr; end
            end
        end
    endtask

    task automatic start_flush(input logic [31:0] t);
        mdl_flush_left   = FC;
        mdl_redirect_due = 1;
        mdl_target       = t;
    endtask

    // called just after a falling edge with inputs already driven
    task automatic step();
        bit          hit, bvw;
        logic [4:0]  code;
        logic [31:0] bv, epc_live, nip;
        logic        e_ivx, e_bd, e_bvw, e_eret, e_flush, e_rv;
        logic [4:0]  e_code;
        logic [31:0] e_epc, e_bv, e_rpc;

        #2;
        classify(hit, code, bvw, bv);
        epc_live = bus.m_is_bd ? bus.m_pc - 32'd4 : bus.m_pc;
        e_ivx = 0; e_bd = 0; e_bvw = 0; e_eret = 0; e_flush = 0; e_rv = 0;
        e_code = 0; e_epc = 0; e_bv = 0; e_rpc = 0;
        if (!resetn) begin
            // everything stays zero
        end else if (mdl_pending) begin
            e_ivx = 1; e_epc = pend_epc; e_bd = pend_bd; e_code = pend_code;
            e_bvw = pend_bvw; e_bv = pend_bv;
        end else if (mdl_flush_left > 0) begin
            e_flush = 1;
            if (mdl_redirect_due) begin e_rv = 1; e_rpc = mdl_target; end
        end else if (bus.m_valid) begin
            if (hit) begin
                e_ivx = 1; e_epc = epc_live; e_bd = bus.m_is_bd; e_code = code;
                e_bvw = bvw; e_bv = bv;
            end else if (bus.m_eret && !bus.m_stall) begin
                e_eret = 1;
            end
        end

        check("is_valid_exc",   32'(bus.is_valid_exc),        32'(e_ivx));
        check("epc_wdata",      bus.epc_wdata,                e_epc);
        check("cause_bd",       32'(bus.cause_bd_wdata),      32'(e_bd));
        check("exccode",        32'(bus.cause_exccode_wdata), 32'(e_code));
        check("badvaddr_wen",   32'(bus.badvaddr_wen),        32'(e_bvw));
        check("badvaddr_wdata", bus.badvaddr_wdata,           e_bv);
        check("eret_commit",    32'(bus.eret_commit),         32'(e_eret));
        check("flush",          32'(bus.flush),               32'(e_flush));
        check("redirect_valid", 32'(bus.redirect_valid),      32'(e_rv));
        check("redirect_pc",    bus.redirect_pc,              e_rpc);

        nip = 32'((|(bus.cp0_cause[15:8] & bus.cp0_status[15:8]))
                  && bus.cp0_status[0] && !bus.cp0_status[1]);
        @(posedge clk);
        if (!resetn) begin
            mdl_pending = 0; mdl_flush_left = 0; mdl_redirect_due = 0;
            mdl_int_pend = 0;
        end else begin
            if (mdl_pending) begin
                if (!bus.m_stall) begin
                    mdl_pending = 0;
                    start_flush(VEC);
                end
            end else if (mdl_flush_left > 0) begin
                mdl_redirect_due = 0;
                mdl_flush_left--;
            end else if (bus.m_valid && hit) begin
                pend_epc = epc_live; pend_bd = bus.m_is_bd; pend_code = code;
                pend_bvw = bvw; pend_bv = bv;
                if (bus.m_stall) mdl_pending = 1;
                else start_flush(VEC);
            end else if (bus.m_valid && bus.m_eret && !bus.m_stall) begin
                start_flush(bus.cp0_epc);
            end
            mdl_int_pend = nip[0];
        end
        @(negedge clk);
    endtask

    task automatic quiet();
        bus.m_valid = 0; bus.m_stall = 0; bus.m_pc = 0; bus.m_is_bd = 0; bus.m_addr = 0;
        bus.f_adel = 0; bus.d_ri = 0; bus.e_ov = 0; bus.d_sys = 0; bus.d_bp = 0;
        bus.m_adel = 0; bus.m_ades = 0; bus.m_eret = 0;
        bus.cp0_status = 0; bus.cp0_cause = 0; bus.cp0_epc = 0;
    endtask

    initial begin
        mdl_int_pend = 0; mdl_pending = 0; mdl_flush_left = 0;
        mdl_redirect_due = 0; mdl_target = 0;
        pend_epc = 0; pend_bv = 0; pend_bd = 0; pend_bvw = 0; pend_code = 0;
        quiet();
        resetn = 0;
        @(negedge clk);
        // reset with an exception presented: outputs must stay zero
        bus.m_valid = 1; bus.d_ri = 1; bus.m_pc = 32'h1234_5678;
        step();
        step();
        quiet();
        resetn = 1;
        step();

        // RI, no stall
        bus.m_valid = 1; bus.m_pc = 32'h8000_0100; bus.d_ri = 1;
        step();
        quiet();
        step(); step();

        // AdES in delay slot, stalled for three cycles
        bus.m_valid = 1; bus.m_is_bd = 1; bus.m_pc = 32'h8000_0204;
        bus.m_addr = 32'h0000_1003; bus.m_ades = 1; bus.m_stall = 1;
        step(); step(); step();
        bus.m_stall = 0;
        step();
        quiet();
        step(); step();

        // interrupt enabled, then masked by EXL
        bus.cp0_status = 32'h0000_0401; bus.cp0_cause = 32'h0000_0400;
        step();
        bus.m_valid = 1; bus.m_pc = 32'h8000_0300;
        step();
        bus.m_valid = 0; bus.cp0_cause = 0;
        step(); step();
        bus.cp0_status = 32'h0000_0403; bus.cp0_cause = 32'h0000_0400;
        step();
        bus.m_valid = 1;
        step(); step();
        quiet();
        step();

        // simultaneous fetch AdEL, Ov, Sys; also EPC wrap from a BD slot at 0
        bus.m_valid = 1; bus.m_pc = 32'h0000_0002; bus.f_adel = 1; bus.e_ov = 1; bus.d_sys = 1;
        step();
        quiet();
        step(); step();
        bus.m_valid = 1; bus.m_pc = 32'h0000_0000; bus.m_is_bd = 1; bus.d_bp = 1;
        step();
        quiet();
        step(); step();

        // ERET, then a second ERET during FLUSH
        bus.m_valid = 1; bus.m_eret = 1; bus.cp0_epc = 32'h8000_1000;
        step();
        bus.cp0_epc = 32'h8000_2000;
        step();
        quiet();
        step();

        // reset in the middle of HOLD: no redirect afterwards
        bus.m_valid = 1; bus.m_adel = 1; bus.m_addr = 32'h0000_0005; bus.m_stall = 1;
        step(); step();
        resetn = 0;
        step();
        resetn = 1; bus.m_stall = 0;
        quiet();
        step(); step(); step();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bus.m_valid    = ($urandom % 8) != 0;
            bus.m_stall    = ($urandom % 4) == 0;
            bus.m_pc       = $urandom;
            bus.m_is_bd    = ($urandom % 2) == 0;
            bus.m_addr     = $urandom;
            bus.f_adel     = ($urandom % 14) == 0;
            bus.d_ri       = ($urandom % 14) == 0;
            bus.e_ov       = ($urandom % 14) == 0;
            bus.d_sys      = ($urandom % 14) == 0;
            bus.d_bp       = ($urandom % 14) == 0;
            bus.m_adel     = ($urandom % 14) == 0;
            bus.m_ades     = ($urandom % 14) == 0;
            bus.m_eret     = ($urandom % 6) == 0;
            bus.cp0_status = {16'h0, 8'($urandom), 6'h0, 2'($urandom)};
            bus.cp0_cause  = (($urandom % 6) == 0) ? {16'h0, 8'($urandom), 8'h0} : 32'h0;
            bus.cp0_epc    = $urandom;
            resetn         = ($urandom % 300) != 0;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
